dp_sequencer: RTL and testbench

//  Program-driven controller for the 5-stage SIMD data_path (typeA x2, typeB, typeC x2, typeD).

---
 rtl/dp_seq_pkg.sv | 61 ++++++
 rtl/ctrl_delay_line.sv | 37 +++
 rtl/dp_sequencer.sv | 205 ++++++++++++++++++++
 tb/tb_dp_sequencer.sv | 394 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dp_seq_pkg.sv
// Shared types and constants for the data_path sequencer.
// Holds the control word layout, per-stage slot layout, stage timing offsets and FSM states.
// Imported by dp_sequencer and its testbench.
package dp_seq_pkg;

  localparam int PROG_DEPTH = 16;                 // control words in program memory (power of 2)
  localparam int REP_W      = 8;                  // repeat field width, beats = rep+1
  localparam int PIPE_LAT   = 4;                  // stage-0 issue to valid stream_out
  localparam int N_STG      = 5;                  // controlled stages (num_col-1)
  localparam int NUM_COL    = N_STG + 1;          // data_path columns
  localparam int RFA_W      = 4;                  // dwidth_RFadd: register-file address width

  localparam int PC_W       = $clog2(PROG_DEPTH);
  localparam int LEN_W      = PC_W + 1;           // prog_len can equal PROG_DEPTH
  localparam int DRN_W      = $clog2(PIPE_LAT + 1);

  // Cycles between issue and the moment each stage consumes its controls.
  // Stage order: typeA0, typeA1, typeC0, typeC1, typeD.
  localparam int STG_OFS [N_STG] = '{0, 0, 1, 2, 3};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  // One program word; per-stage fields are packed with stage k in the k-th slice.
  typedef struct packed {
    logic [4*N_STG-1:0]     sel;
    logic [2*N_STG-1:0]     op;
    logic [N_STG-1:0]       wen;
    logic [RFA_W*N_STG-1:0] rd;
    logic [RFA_W*N_STG-1:0] wr;
    logic [REP_W-1:0]       rep;
  } ctrl_word_t;

  localparam int CW_W = $bits(ctrl_word_t);

  // Controls belonging to a single stage, as carried down its delay line.
  typedef struct packed {
    logic [3:0]       sel;
    logic [1:0]       op;
    logic             wen;
    logic [RFA_W-1:0] rd;
    logic [RFA_W-1:0] wr;
  } stg_slot_t;

  localparam int SLOT_W = $bits(stg_slot_t);

  // Extract stage k's controls from a full program word.
  function automatic stg_slot_t stage_slot(input ctrl_word_t cw, input int k);
    stg_slot_t s;
    s.sel = cw.sel[4*k +: 4];
    s.op  = cw.op[2*k +: 2];
    s.wen = cw.wen[k];
    s.rd  = cw.rd[RFA_W*k +: RFA_W];
    s.wr  = cw.wr[RFA_W*k +: RFA_W];
    return s;
  endfunction

endpackage

// File: rtl/ctrl_delay_line.sv
// Purpose : resettable W-bit shift register used to time-align stage controls and out_valid.
// Latency : DEPTH cycles from d_i to q_o (DEPTH >= 1).
// Backpr. : none; shifts every cycle.
//
// Ports
//   clk    in  1  clock
//   rst_n  in  1  async active-low reset, clears every tap
//   d_i    in  W  value entering the line
//   q_o    out W  value entered DEPTH cycles earlier
module ctrl_delay_line #(
  parameter int W     = 1,
  parameter int DEPTH = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] pipe_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      pipe_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign q_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/dp_sequencer.sv
// Purpose : program-driven controller stepping the 5-stage SIMD data_path, one word per accepted phit.
// Latency : stage 0/1 controls same cycle as issue, stages 2..4 at +1..+3, out_valid at +PIPE_LAT.
// Backpr. : in_ready only while running and not aborting; output side has no backpressure.
//
// Ports
//   clk, rst_n        clock and async active-low reset
//   cfg_we_i/addr/wdata  program memory write port, honoured only while idle
//   start_i, prog_len_i  launch a program of prog_len words (sampled in IDLE)
//   abort_i           stop issuing, let in-flight beats finish
//   in_valid_i/in_ready_o  inbound phit handshake; both high = issue
//   sel_mux4_o, op_o, wen_RF_o, rd_addr_RF_o, wr_addr_RF_o  per-stage controls, stage k in slice k
//   out_valid_o       stream_out carries the result of an issued beat
//   busy_o            not IDLE
//   done_o            one-cycle pulse when a program (or empty start) completes
module dp_sequencer
  import dp_seq_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cfg_we_i,
  input  logic [PC_W-1:0]          cfg_addr_i,
  input  logic [CW_W-1:0]          cfg_wdata_i,
  input  logic                     start_i,
  input  logic [LEN_W-1:0]         prog_len_i,
  input  logic                     abort_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  output logic [4*N_STG-1:0]       sel_mux4_o,
  output logic [2*N_STG-1:0]       op_o,
  output logic [NUM_COL-1:0]       wen_RF_o,
  output logic [RFA_W*N_STG-1:0]   rd_addr_RF_o,
  output logic [RFA_W*N_STG-1:0]   wr_addr_RF_o,
  output logic                     out_valid_o,
  output logic                     busy_o,
  output logic                     done_o
);

  // ---------------------------------------------------------------------------
  // Program memory: single write port, asynchronous read at pc. Not reset, so a
  // loaded program survives a reset pulse.
  // ---------------------------------------------------------------------------
  logic [CW_W-1:0] prog_mem [PROG_DEPTH];

  state_e           state_q;
  logic [PC_W-1:0]  pc_q;
  logic [REP_W-1:0] rep_cnt_q;
  logic [LEN_W-1:0] len_q;
  logic [DRN_W-1:0] drain_cnt_q;
  logic             done_q;

  ctrl_word_t cw;
  logic       issue;
  logic       rep_hit;
  logic       last_beat;

  always_ff @(posedge clk) begin
    if (cfg_we_i && (state_q == IDLE)) begin
      prog_mem[cfg_addr_i] <= cfg_wdata_i;
    end
  end

  assign cw = ctrl_word_t'(prog_mem[pc_q]);

  // Abort blocks acceptance in the very cycle it is asserted.
  assign in_ready_o = (state_q == RUN) && !abort_i;
  assign issue      = in_valid_i && in_ready_o;

  // Current word has delivered its final repeat on this beat.
  assign rep_hit    = (rep_cnt_q == cw.rep);
  assign last_beat  = rep_hit && ({1'b0, pc_q} == (len_q - LEN_W'(1)));

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pc_q        <= '0;
      rep_cnt_q   <= '0;
      len_q       <= '0;
      drain_cnt_q <= '0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            if (prog_len_i != '0) begin
              state_q   <= RUN;
              len_q     <= prog_len_i;
              pc_q      <= '0;
              rep_cnt_q <= '0;
            end else begin
              // Empty program completes immediately.
              done_q <= 1'b1;
            end
          end
        end

        RUN: begin
          if (issue) begin
            if (rep_hit) begin
              rep_cnt_q <= '0;
              pc_q      <= pc_q + PC_W'(1);
            end else begin
              rep_cnt_q <= rep_cnt_q + REP_W'(1);
            end
          end
          // abort suppresses issue, so abort and last beat never both fire;
          // either way a single DRAIN entry results.
          if ((issue && last_beat) || abort_i) begin
            state_q     <= DRAIN;
            drain_cnt_q <= '0;
          end
        end

        DRAIN: begin
          // Wait for the last issued beat to reach stream_out.
          if (drain_cnt_q == DRN_W'(PIPE_LAT - 1)) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end else begin
            drain_cnt_q <= drain_cnt_q + DRN_W'(1);
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy_o = (state_q != IDLE);
  assign done_o = done_q;

  // ---------------------------------------------------------------------------
  // Per-stage control alignment. Each stage sees the word issued STG_OFS[k]
  // cycles earlier; a slot-valid bit travels alongside so bubbles can be told
  // apart from real beats. On a bubble the stage keeps its last sel/op/addr
  // (avoids needless mux toggling) but its RF write enable is forced low.
  // ---------------------------------------------------------------------------
  for (genvar k = 0; k < N_STG; k++) begin : g_stg
    stg_slot_t slot_in;
    stg_slot_t tap;
    stg_slot_t hold_q;
    stg_slot_t cur;
    logic      tap_vld;

    assign slot_in = stage_slot(cw, k);

    if (STG_OFS[k] == 0) begin : g_direct
      assign tap_vld = issue;
      assign tap     = slot_in;
    end else begin : g_dly
      logic [SLOT_W:0] dly_out;

      ctrl_delay_line #(
        .W     (SLOT_W + 1),
        .DEPTH (STG_OFS[k])
      ) u_dly (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   ({issue, slot_in}),
        .q_o   (dly_out)
      );

      assign tap_vld = dly_out[SLOT_W];
      assign tap     = stg_slot_t'(dly_out[SLOT_W-1:0]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        hold_q <= '0;
      end else if (tap_vld) begin
        hold_q <= tap;
      end
    end

    assign cur = tap_vld ? tap : hold_q;

    assign sel_mux4_o[4*k +: 4]           = cur.sel;
    assign op_o[2*k +: 2]                 = cur.op;
    assign wen_RF_o[k]                    = cur.wen && tap_vld;
    assign rd_addr_RF_o[RFA_W*k +: RFA_W] = cur.rd;
    assign wr_addr_RF_o[RFA_W*k +: RFA_W] = cur.wr;
  end

  // Last column has no register file to write.
  assign wen_RF_o[NUM_COL-1] = 1'b0;

  // ---------------------------------------------------------------------------
  // out_valid: every issued beat emerges PIPE_LAT cycles later.
  // ---------------------------------------------------------------------------
  ctrl_delay_line #(
    .W     (1),
    .DEPTH (PIPE_LAT)
  ) u_out_vld (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (issue),
    .q_o   (out_valid_o)
  );

endmodule

// File: tb/tb_dp_sequencer.sv
// Purpose : self-checking bench for dp_sequencer using a cycle model and per-stage scoreboards.
// Latency : n/a
// Backpr. : drives in_valid patterns and abort; output side is always accepted.
module tb_dp_sequencer;
  import dp_seq_pkg::*;

  localparam logic [1:0] OP_ADD = 2'b00;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b1;
  logic                   cfg_we_i = 1'b0;
  logic [PC_W-1:0]        cfg_addr_i = '0;
  logic [CW_W-1:0]        cfg_wdata_i = '0;
  logic                   start_i = 1'b0;
  logic [LEN_W-1:0]       prog_len_i = '0;
  logic                   abort_i = 1'b0;
  logic                   in_valid_i = 1'b0;
  logic                   in_ready_o;
  logic [4*N_STG-1:0]     sel_mux4_o;
  logic [2*N_STG-1:0]     op_o;
  logic [NUM_COL-1:0]     wen_RF_o;
  logic [RFA_W*N_STG-1:0] rd_addr_RF_o;
  logic [RFA_W*N_STG-1:0] wr_addr_RF_o;
  logic                   out_valid_o;
  logic                   busy_o;
  logic                   done_o;

  always #5 clk = ~clk;

  dp_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg_we_i     (cfg_we_i),
    .cfg_addr_i   (cfg_addr_i),
    .cfg_wdata_i  (cfg_wdata_i),
    .start_i      (start_i),
    .prog_len_i   (prog_len_i),
    .abort_i      (abort_i),
    .in_valid_i   (in_valid_i),
    .in_ready_o   (in_ready_o),
    .sel_mux4_o   (sel_mux4_o),
    .op_o         (op_o),
    .wen_RF_o     (wen_RF_o),
    .rd_addr_RF_o (rd_addr_RF_o),
    .wr_addr_RF_o (wr_addr_RF_o),
    .out_valid_o  (out_valid_o),
    .busy_o       (busy_o),
    .done_o       (done_o)
  );

  int n_chk  = 0;
  int n_pass = 0;

  ctrl_word_t mem_m [PROG_DEPTH];

  typedef struct {
    int cyc;
    int word;
  } ev_t;

  ev_t q_ov[$];
  ev_t q2[$];
  ev_t q3[$];
  ev_t q4[$];

  // Expected held values at stage 4 (only change when a real beat arrives).
  logic [1:0]       hold_op4 = '0;
  logic [RFA_W-1:0] hold_rd4 = '0;

  function automatic ctrl_word_t mk_word(input int rep, input logic [N_STG-1:0] wen);
    ctrl_word_t w;
    w.sel = (4*N_STG)'($urandom);
    w.op  = (2*N_STG)'($urandom);
    w.wen = wen;
    w.rd  = (RFA_W*N_STG)'($urandom);
    w.wr  = (RFA_W*N_STG)'($urandom);
    w.rep = REP_W'(rep);
    return w;
  endfunction

  task automatic load_word(input int idx, input ctrl_word_t w);
    @(posedge clk); #1;
    cfg_we_i    = 1'b1;
    cfg_addr_i  = PC_W'(idx);
    cfg_wdata_i = w;
    @(posedge clk); #1;
    cfg_we_i    = 1'b0;
    mem_m[idx]  = w;
  endtask

  // Launch a program and check every cycle until the done pulse.
  task automatic run(input int len, input logic [63:0] vmask, input int abort_at, output int n_ov);
    int         m_pc, m_rep, dcnt;
    state_e     m_st;
    logic       done_exp, fin, iss, last, rdy_exp, exp_b;
    ctrl_word_t w;
    ev_t        e;
    q_ov.delete(); q2.delete(); q3.delete(); q4.delete();
    n_ov = 0; m_pc = 0; m_rep = 0; dcnt = 0; m_st = RUN; done_exp = 1'b0; fin = 1'b0;
    @(posedge clk); #1;
    start_i    = 1'b1;
    prog_len_i = LEN_W'(len);
    for (int c = 0; c < 300 && !fin; c++) begin
      @(posedge clk); #1;
      start_i    = 1'b0;
      in_valid_i = (c < 64) ? vmask[c] : 1'b1;
      abort_i    = (c == abort_at);
      @(negedge clk);
      rdy_exp = (m_st == RUN) && !abort_i;
      iss     = rdy_exp && in_valid_i;
      n_chk++;
      if (in_ready_o !== rdy_exp) $display("FAIL in_ready cyc=%0d got=%b exp=%b", c, in_ready_o, rdy_exp);
      else n_pass++;
      n_chk++;
      if (busy_o !== (m_st != IDLE)) $display("FAIL busy cyc=%0d got=%b exp=%b", c, busy_o, (m_st != IDLE));
      else n_pass++;
      n_chk++;
      if (done_o !== done_exp) $display("FAIL done cyc=%0d got=%b exp=%b", c, done_o, done_exp);
      else n_pass++;
      last = 1'b0;
      if (iss) begin
        w = mem_m[m_pc];
        n_chk++;
        if (op_o[1:0] !== w.op[1:0]) $display("FAIL op_stg0 cyc=%0d got=%h exp=%h", c, op_o[1:0], w.op[1:0]);
        else n_pass++;
        e.word = m_pc;
        e.cyc = c + PIPE_LAT; q_ov.push_back(e);
        e.cyc = c + 1;        q2.push_back(e);
        e.cyc = c + 2;        q3.push_back(e);
        e.cyc = c + 3;        q4.push_back(e);
        last = (m_pc == len - 1) && (m_rep == int'(w.rep));
        if (m_rep == int'(w.rep)) begin
          m_rep = 0;
          m_pc++;
        end else begin
          m_rep++;
        end
      end
      // out_valid scoreboard
      exp_b = (q_ov.size() > 0) && (q_ov[0].cyc == c);
      if (exp_b) e = q_ov.pop_front();
      if (out_valid_o === 1'b1) n_ov++;
      n_chk++;
      if (out_valid_o !== exp_b) $display("FAIL out_valid cyc=%0d got=%b exp=%b", c, out_valid_o, exp_b);
      else n_pass++;
      // stage 2 write enable
      exp_b = 1'b0;
      if ((q2.size() > 0) && (q2[0].cyc == c)) begin
        e = q2.pop_front();
        w = mem_m[e.word];
        exp_b = w.wen[2];
      end
      n_chk++;
      if (wen_RF_o[2] !== exp_b) $display("FAIL wen_stg2 cyc=%0d got=%b exp=%b", c, wen_RF_o[2], exp_b);
      else n_pass++;
      // stage 3 write enable
      exp_b = 1'b0;
      if ((q3.size() > 0) && (q3[0].cyc == c)) begin
        e = q3.pop_front();
        w = mem_m[e.word];
        exp_b = w.wen[3];
      end
      n_chk++;
      if (wen_RF_o[3] !== exp_b) $display("FAIL wen_stg3 cyc=%0d got=%b exp=%b", c, wen_RF_o[3], exp_b);
      else n_pass++;
      // stage 4: wen, held op and rd address
      exp_b = 1'b0;
      if ((q4.size() > 0) && (q4[0].cyc == c)) begin
        e = q4.pop_front();
        w = mem_m[e.word];
        exp_b    = w.wen[4];
        hold_op4 = w.op[9:8];
        hold_rd4 = w.rd[4*RFA_W +: RFA_W];
      end
      n_chk++;
      if (wen_RF_o[4] !== exp_b) $display("FAIL wen_stg4 cyc=%0d got=%b exp=%b", c, wen_RF_o[4], exp_b);
      else n_pass++;
      n_chk++;
      if (op_o[9:8] !== hold_op4) $display("FAIL op_stg4 cyc=%0d got=%h exp=%h", c, op_o[9:8], hold_op4);
      else n_pass++;
      n_chk++;
      if (rd_addr_RF_o[4*RFA_W +: RFA_W] !== hold_rd4)
        $display("FAIL rd_stg4 cyc=%0d got=%h exp=%h", c, rd_addr_RF_o[4*RFA_W +: RFA_W], hold_rd4);
      else n_pass++;
      n_chk++;
      if (wen_RF_o[NUM_COL-1] !== 1'b0) $display("FAIL wen_last_col cyc=%0d got=%b exp=0", c, wen_RF_o[NUM_COL-1]);
      else n_pass++;
      // model next state
      done_exp = 1'b0;
      if (m_st == IDLE) begin
        fin = 1'b1;
      end else if (m_st == RUN) begin
        if (last || abort_i) begin
          m_st = DRAIN;
          dcnt = 0;
        end
      end else begin
        if (dcnt == PIPE_LAT - 1) begin
          m_st     = IDLE;
          done_exp = 1'b1;
        end else begin
          dcnt++;
        end
      end
    end
    in_valid_i = 1'b0;
    abort_i    = 1'b0;
    n_chk++;
    if (!fin) $display("FAIL run_timeout got=not_done exp=done");
    else n_pass++;
    n_chk++;
    if (q_ov.size() != 0) $display("FAIL ov_pending got=%0d exp=0", q_ov.size());
    else n_pass++;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #3;
    n_chk++;
    if ({in_ready_o, out_valid_o, busy_o, done_o} !== 4'b0)
      $display("FAIL reset_ctl got=%b exp=0000", {in_ready_o, out_valid_o, busy_o, done_o});
    else n_pass++;
    n_chk++;
    if ({sel_mux4_o, op_o, wen_RF_o, rd_addr_RF_o, wr_addr_RF_o} !== '0)
      $display("FAIL reset_stage got=%h exp=0", {sel_mux4_o, op_o, wen_RF_o, rd_addr_RF_o, wr_addr_RF_o});
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    hold_op4 = '0;
    hold_rd4 = '0;
  endtask

  task automatic test_single();
    ctrl_word_t w;
    int         nov;
    w = mk_word(0, '1);
    w.op[1:0] = OP_ADD;
    load_word(0, w);
    run(1, '1, -1, nov);
    n_chk++;
    if (nov !== 1) $display("FAIL single_ov_count got=%0d exp=1", nov);
    else n_pass++;
  endtask

  task automatic test_repeat();
    int nov;
    load_word(0, mk_word(2, '1));
    load_word(1, mk_word(0, '1));
    run(2, '1, -1, nov);
    n_chk++;
    if (nov !== 4) $display("FAIL repeat_ov_count got=%0d exp=4", nov);
    else n_pass++;
  endtask

  task automatic test_bubble();
    int nov;
    load_word(0, mk_word(1, '1));
    run(1, 64'b101, -1, nov);
    n_chk++;
    if (nov !== 2) $display("FAIL bubble_ov_count got=%0d exp=2", nov);
    else n_pass++;
  endtask

  task automatic test_abort();
    int nov;
    load_word(0, mk_word(4, 5'b10110));
    run(1, '1, 2, nov);
    n_chk++;
    if (nov !== 2) $display("FAIL abort_ov_count got=%0d exp=2", nov);
    else n_pass++;
  endtask

  task automatic test_zero_len();
    @(posedge clk); #1;
    start_i    = 1'b1;
    prog_len_i = '0;
    in_valid_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    @(negedge clk);
    n_chk++;
    if ({done_o, busy_o, in_ready_o} !== 3'b100)
      $display("FAIL zero_len_pulse got=%b exp=100", {done_o, busy_o, in_ready_o});
    else n_pass++;
    @(negedge clk);
    n_chk++;
    if ({done_o, busy_o, out_valid_o} !== 3'b000)
      $display("FAIL zero_len_after got=%b exp=000", {done_o, busy_o, out_valid_o});
    else n_pass++;
    in_valid_i = 1'b0;
  endtask

  task automatic test_cfg_busy();
    ctrl_word_t w_new;
    logic       seen;
    int         nov;
    w_new = mk_word(0, '1);
    w_new.op = ~mem_m[0].op;
    @(posedge clk); #1;
    start_i    = 1'b1;
    prog_len_i = LEN_W'(1);
    in_valid_i = 1'b0;
    @(posedge clk); #1;
    start_i     = 1'b0;
    cfg_we_i    = 1'b1;
    cfg_addr_i  = '0;
    cfg_wdata_i = w_new;
    @(negedge clk);
    n_chk++;
    if (busy_o !== 1'b1) $display("FAIL cfg_busy_state got=%b exp=1", busy_o);
    else n_pass++;
    @(posedge clk); #1;
    cfg_we_i = 1'b0;
    abort_i  = 1'b1;
    @(posedge clk); #1;
    abort_i = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (done_o === 1'b1) seen = 1'b1;
    end
    n_chk++;
    if (!seen) $display("FAIL cfg_abort_done got=0 exp=1");
    else n_pass++;
    // mem_m[0] untouched: the run checks stage-0 op against the original word
    run(1, '1, -1, nov);
  endtask

  task automatic test_reset_mid_run();
    int nov;
    load_word(0, mk_word(3, '1));
    load_word(1, mk_word(0, '1));
    @(posedge clk); #1;
    start_i    = 1'b1;
    prog_len_i = LEN_W'(2);
    in_valid_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    @(posedge clk);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if ({in_ready_o, out_valid_o, busy_o, done_o} !== 4'b0)
      $display("FAIL midrst_ctl got=%b exp=0000", {in_ready_o, out_valid_o, busy_o, done_o});
    else n_pass++;
    n_chk++;
    if ({sel_mux4_o, op_o, wen_RF_o, rd_addr_RF_o, wr_addr_RF_o} !== '0)
      $display("FAIL midrst_stage got=%h exp=0", {sel_mux4_o, op_o, wen_RF_o, rd_addr_RF_o, wr_addr_RF_o});
    else n_pass++;
    in_valid_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    hold_op4 = '0;
    hold_rd4 = '0;
    run(2, '1, -1, nov);
    n_chk++;
    if (nov !== 5) $display("FAIL midrst_restart_ov got=%0d exp=5", nov);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int nov;
    load_word(0, mk_word(1, 5'b01011));
    load_word(1, mk_word(2, 5'b11100));
    load_word(2, mk_word(0, '1));
    run(3, 64'hFFFF_FFFF_FFFF_FF6D, -1, nov);
    run(2, '1, -1, nov);
    n_chk++;
    if (nov !== 5) $display("FAIL b2b_ov_count got=%0d exp=5", nov);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_repeat();
    test_bubble();
    test_abort();
    test_zero_len();
    test_cfg_busy();
    test_reset_mid_run();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
